xor_descrambler32: RTL and testbench
====================================

XOR_DESCRAMBLER32 -- requirements
Module: xor_descrambler32

Interface
REQ-001 SHALL: parameter CNT_W, default 16, width of the accepted-word counter.
REQ-002 SHALL: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL: reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL: seed_valid  input  1  load seed this cycle.
REQ-005 SHALL: seed  input  32  keystream LFSR seed.
REQ-006 SHALL: in_valid  input  1  scrambled word present.
REQ-007 SHALL: in_ready  output  1  block accepts in_data this cycle.
REQ-008 SHALL: in_data  input  32  scrambled word.
REQ-009 SHALL: out_valid  output  1  descrambled word present.
REQ-010 SHALL: out_ready  input  1  downstream accepts out_data.
REQ-011 SHALL: out_data  output  32  descrambled word.
REQ-012 SHALL: word_cnt  output  CNT_W  words accepted since last seed load, wraps at 2^CNT_W.
REQ-013 SHALL: busy  output  1  high in state RUN.

Function
REQ-014 SHALL: FSM states IDLE (unseeded) and RUN; IDLE->RUN on seed_valid; RUN->RUN on seed_valid (reseed); no other transitions except reset->IDLE.
REQ-015 SHALL: in_ready = (state==RUN) && !seed_valid && (!out_valid || out_ready); in IDLE in_ready=0.
REQ-016 SHALL: seed load sets lfsr <= seed, except seed==0 loads 32'h0000_0001 (lockup avoidance).
REQ-017 SHALL: keystream word = current lfsr; single step: fb = s[31]^s[21]^s[1]^s[0], s <= {s[30:0], fb}; lfsr advances by exactly 32 steps per accepted word.
REQ-018 SHALL: on accept (in_valid && in_ready): out_data <= in_data ^ lfsr, out_valid <= 1, word_cnt += 1; latency 1 cycle.
REQ-019 SHALL: out_valid clears when out_ready && !accept; simultaneous drain and accept keeps out_valid=1 with new data (full throughput, 1 word/cycle).
REQ-020 SHALL: out_data stable while out_valid && !out_ready.
REQ-021 SHALL: reseed in RUN clears word_cnt to 0, leaves any pending output word intact, blocks input that cycle.
REQ-022 SHALL: word_cnt wraps from 2^CNT_W-1 to 0 without flag.
REQ-023 SHALL: in_valid in IDLE is ignored; no data dropped silently once accepted.

Reset
REQ-024 SHALL: reset forces state=IDLE, lfsr=32'h0000_0001, out_valid=0, out_data=0, word_cnt=0, busy=0, in_ready=0.
REQ-025 SHALL: reset mid-stream discards pending output word; reset overrides seed_valid in same cycle.

Configuration
REQ-026 SHALL: macro XOR_DESCRAMBLER32_PARITY_EN, when defined, adds input in_par (1, even parity of scrambled word) and output par_err (1, sticky).
REQ-027 SHALL: with macro, on accept par_err <= par_err | (^in_data ^ in_par); cleared by reset or seed load; word still delivered.
REQ-028 SHALL: without macro, ports in_par/par_err absent, no parity logic.

Structure
REQ-029 SHALL: shared package holds LFSR tap constants, reset seed 32'h0000_0001, state enum (IDLE, RUN), and the 32-step advance function.
REQ-030 SHALL: XOR of data and keystream performed by existing 32-bit bitwise XOR cell, instantiated as the only sub-module.

Verification
REQ-031 SHALL: seed=0x0000_0001, in_data=0x0000_0000 -> out_data=0x0000_0001 one cycle later, word_cnt=1.
REQ-032 SHALL: seed=0 -> behaves identically to seed=0x0000_0001 (same first two outputs).
REQ-033 SHALL: 8 words back-to-back from paired scrambler model, out_ready held 1 -> 8 outputs equal plaintext, in_ready never low, word_cnt=8.
REQ-034 SHALL: out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, out_data unchanged, nothing lost on release.
REQ-035 SHALL: seed_valid and in_valid same cycle in RUN -> input not accepted, word_cnt=0, next accepted word uses new seed.
REQ-036 SHALL: with XOR_DESCRAMBLER32_PARITY_EN, in_data=0x0000_0001, in_par=0 -> par_err=1 and stays 1 until reseed.

Source files
------------

// File: rtl/xor_descrambler32_pkg.sv
// Shared definitions for xor_descrambler32: keystream LFSR taps and reset seed,
// FSM state encoding, and the LFSR advance and parity helpers.
package xor_descrambler32_pkg;

    // Feedback taps at bits 31, 21, 1 and 0
    localparam logic [31:0] LFSR_TAPS       = 32'h8020_0003;
    localparam logic [31:0] LFSR_RESET_SEED = 32'h0000_0001;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], ^(s & LFSR_TAPS)};
    endfunction

    // One keystream word consumes 32 single steps
    function automatic logic [31:0] lfsr_advance32(input logic [31:0] s);
        logic [31:0] v;
        v = s;
        for (int i = 0; i < 32; i++) begin
            v = lfsr_step(v);
        end
        return v;
    endfunction

    function automatic logic even_parity(input logic [31:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/xor_descrambler32_xor.sv
// 32-bit bitwise XOR cell combining scrambled data with the keystream word.
module xor_descrambler32_xor (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    assign y = a ^ b;

endmodule

// File: rtl/xor_descrambler32.sv
// Additive (XOR) 32-bit descrambler with seedable keystream LFSR and a
// one-word output register. Optional parity check: XOR_DESCRAMBLER32_PARITY_EN.
module xor_descrambler32
    import xor_descrambler32_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             seed_valid,
    input  logic [31:0]      seed,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
`ifdef XOR_DESCRAMBLER32_PARITY_EN
    input  logic             in_par,
    output logic             par_err,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] word_cnt,
    output logic             busy
);

    state_t             state_r;
    logic [31:0]        lfsr_r;
    logic               out_valid_r;
    logic [31:0]        out_data_r;
    logic [CNT_W-1:0]   word_cnt_r;
    logic               in_ready_s;
    logic               accept_s;
    logic [31:0]        plain_s;
    logic [31:0]        seed_load_s;

    xor_descrambler32_xor u_xor (
        .a (in_data),
        .b (lfsr_r),
        .y (plain_s)
    );

    // Input handshake: reseed cycles and a stalled output register block input
    always_comb begin
        in_ready_s = 1'b0;
        if (state_r == RUN) begin
            in_ready_s = !seed_valid && (!out_valid_r || out_ready);
        end else begin
            in_ready_s = 1'b0;
        end
    end

    assign accept_s    = in_valid && in_ready_s;
    assign seed_load_s = (seed == 32'h0000_0000) ? LFSR_RESET_SEED : seed;

    // FSM, keystream, word counter and output register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            lfsr_r      <= LFSR_RESET_SEED;
            out_valid_r <= 1'b0;
            out_data_r  <= 32'h0000_0000;
            word_cnt_r  <= '0;
        end else begin
            case (state_r)
                IDLE:    if (seed_valid) state_r <= RUN;
                RUN:     state_r <= RUN;
                default: state_r <= IDLE;
            endcase

            if (seed_valid) begin
                lfsr_r     <= seed_load_s;
                word_cnt_r <= '0;
            end else if (accept_s) begin
                lfsr_r     <= lfsr_advance32(lfsr_r);
                word_cnt_r <= word_cnt_r + CNT_W'(1);
            end

            if (accept_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= plain_s;
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

`ifdef XOR_DESCRAMBLER32_PARITY_EN
    logic par_err_r;

    // Sticky parity error, cleared on reset or any seed load
    always_ff @(posedge clk) begin
        if (reset) begin
            par_err_r <= 1'b0;
        end else if (seed_valid) begin
            par_err_r <= 1'b0;
        end else if (accept_s) begin
            par_err_r <= par_err_r | (even_parity(in_data) ^ in_par);
        end
    end

    assign par_err = par_err_r;
`endif

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign word_cnt  = word_cnt_r;
    assign busy      = (state_r == RUN);

endmodule

// File: tb/tb_xor_descrambler32.sv
// Directed bench for xor_descrambler32 with a reference keystream model and an
// expected-word scoreboard queue.
module tb_xor_descrambler32;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          seed_valid = 1'b0;
    logic [31:0]   seed = 32'h0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_data = 32'h0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [31:0]   out_data;
    logic [CW-1:0] word_cnt;
    logic          busy;
`ifdef XOR_DESCRAMBLER32_PARITY_EN
    logic          in_par = 1'b0;
    logic          par_err;
    logic          par_flip = 1'b0;
    logic          m_perr = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    // reference model state
    logic          m_run = 1'b0;
    logic [31:0]   m_lfsr = 32'h1;
    logic          m_ov = 1'b0;
    logic [CW-1:0] m_cnt = '0;
    logic [31:0]   exp_q[$];

    xor_descrambler32 #(.CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .seed_valid (seed_valid),
        .seed       (seed),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
`ifdef XOR_DESCRAMBLER32_PARITY_EN
        .in_par     (in_par),
        .par_err    (par_err),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .word_cnt   (word_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_ks_next(input logic [31:0] s);
        logic [31:0] v;
        logic        fb;
        v = s;
        for (int k = 0; k < 32; k++) begin
            fb = v[31] ^ v[21] ^ v[1] ^ v[0];
            v  = {v[30:0], fb};
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs at negedge, advance the model, return at posedge+1
    task automatic tick();
        logic exp_ready;
        logic acc;
        @(negedge clk);
        if (reset) begin
            m_run  = 1'b0;
            m_lfsr = 32'h1;
            m_ov   = 1'b0;
            m_cnt  = '0;
            exp_q.delete();
`ifdef XOR_DESCRAMBLER32_PARITY_EN
            m_perr = 1'b0;
`endif
        end else begin
            exp_ready = m_run && !seed_valid && (!m_ov || out_ready);
            chk("in_ready", {31'h0, in_ready}, {31'h0, exp_ready});
            chk("out_valid", {31'h0, out_valid}, {31'h0, m_ov});
            chk("busy", {31'h0, busy}, {31'h0, m_run});
            chk("word_cnt", {28'h0, word_cnt}, {28'h0, m_cnt});
`ifdef XOR_DESCRAMBLER32_PARITY_EN
            chk("par_err", {31'h0, par_err}, {31'h0, m_perr});
`endif
            if (m_ov && exp_q.size() > 0) chk("out_data", out_data, exp_q[0]);
            acc = in_valid && exp_ready;
            if (m_ov && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(in_data ^ m_lfsr);
            m_ov = acc ? 1'b1 : (out_ready ? 1'b0 : m_ov);
`ifdef XOR_DESCRAMBLER32_PARITY_EN
            if (seed_valid) m_perr = 1'b0;
            else if (acc) m_perr = m_perr | (^in_data ^ in_par);
`endif
            if (seed_valid) begin
                m_run  = 1'b1;
                m_lfsr = (seed == 32'h0) ? 32'h1 : seed;
                m_cnt  = '0;
            end else if (acc) begin
                m_lfsr = ref_ks_next(m_lfsr);
                m_cnt  = m_cnt + 4'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [31:0] d, input logic sv,
                         input logic [31:0] s, input logic ordy);
        in_valid   = iv;
        in_data    = d;
        seed_valid = sv;
        seed       = s;
        out_ready  = ordy;
`ifdef XOR_DESCRAMBLER32_PARITY_EN
        in_par     = (^d) ^ par_flip;
`endif
        tick();
    endtask

    // Drive plaintext p through the paired scrambler (keystream from model)
    task automatic send_plain(input logic [31:0] p, input logic ordy);
        drive(1'b1, p ^ m_lfsr, 1'b0, 32'h0, ordy);
    endtask

    initial begin
        logic [31:0] plain [8];
        plain = '{32'hDEAD_BEEF, 32'h0000_0000, 32'hFFFF_FFFF, 32'h1234_5678,
                  32'hA5A5_5A5A, 32'h0F0F_F0F0, 32'h8000_0001, 32'hCAFE_F00D};

        // reset, then reset values
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        reset = 1'b0;
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_word_cnt", {28'h0, word_cnt}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);

        // in_valid while unseeded is ignored
        drive(1'b1, 32'h1111_1111, 1'b0, 32'h0, 1'b1);
        drive(1'b1, 32'h2222_2222, 1'b0, 32'h0, 1'b1);
        chk("idle_no_accept", {31'h0, out_valid}, 32'h0);

        // seed 1, data 0 -> keystream word 1
        drive(1'b0, 32'h0, 1'b1, 32'h0000_0001, 1'b1);
        drive(1'b1, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("seed1_first_word", out_data, 32'h0000_0001);
        chk("seed1_word_cnt", {28'h0, word_cnt}, 32'h1);
        drive(1'b1, 32'h0, 1'b0, 32'h0, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

        // seed 0 loads the lockup-avoidance seed
        drive(1'b0, 32'h0, 1'b1, 32'h0000_0000, 1'b1);
        drive(1'b1, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("seed0_first_word", out_data, 32'h0000_0001);
        drive(1'b1, 32'h0, 1'b0, 32'h0, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

        // 8 words back-to-back through the paired scrambler
        drive(1'b0, 32'h0, 1'b1, 32'hACE1_2345, 1'b1);
        for (int i = 0; i < 8; i++) begin
            send_plain(plain[i], 1'b1);
            chk("b2b_plain", out_data, plain[i]);
        end
        chk("b2b_word_cnt", {28'h0, word_cnt}, 32'h8);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

        // backpressure: held word stable, input blocked, nothing lost
        send_plain(32'h5555_AAAA, 1'b0);
        for (int i = 0; i < 3; i++) begin
            send_plain(32'h7777_7777, 1'b0);
            chk("stall_data", out_data, 32'h5555_AAAA);
        end
        send_plain(32'h7777_7777, 1'b1);
        chk("release_data", out_data, 32'h7777_7777);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

        // reseed with in_valid: not accepted, pending word kept, new seed used
        send_plain(32'h1357_9BDF, 1'b0);
        drive(1'b1, 32'hFFFF_0000, 1'b1, 32'h0BAD_CAFE, 1'b0);
        chk("reseed_cnt", {28'h0, word_cnt}, 32'h0);
        chk("reseed_pending", out_data, 32'h1357_9BDF);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        drive(1'b1, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("reseed_keystream", out_data, 32'h0BAD_CAFE);

        // counter wrap at 2^CW
        drive(1'b0, 32'h0, 1'b1, 32'h0000_00F1, 1'b1);
        for (int i = 0; i < 17; i++) send_plain(32'h0000_0100 + i, 1'b1);
        chk("wrap_cnt", {28'h0, word_cnt}, 32'h1);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

`ifdef XOR_DESCRAMBLER32_PARITY_EN
        // bad parity sets sticky par_err, still delivers the word; reseed clears
        par_flip = 1'b1;
        drive(1'b1, 32'h0000_0001, 1'b0, 32'h0, 1'b1);
        par_flip = 1'b0;
        chk("par_err_set", {31'h0, par_err}, 32'h1);
        send_plain(32'h0000_0003, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("par_err_sticky", {31'h0, par_err}, 32'h1);
        drive(1'b0, 32'h0, 1'b1, 32'h0000_0042, 1'b1);
        chk("par_err_clr", {31'h0, par_err}, 32'h0);
`endif

        // reset mid-stream discards pending word and overrides seed_valid
        send_plain(32'h2468_ACE0, 1'b0);
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b1, 32'h9999_9999, 1'b0);
        reset = 1'b0;
        chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("midrst_busy", {31'h0, busy}, 32'h0);
        chk("midrst_out_data", out_data, 32'h0);
        drive(1'b1, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("midrst_idle", {31'h0, out_valid}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
